// File: rtl/onehot_scan_decoder_pkg.sv
// rtl/onehot_scan_decoder_pkg.sv - shared state and mode encodings for the one-hot scan decoder
package onehot_scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// rtl/onehot_scan_decoder_if.sv - control/select inputs and one-hot outputs of the scan decoder
interface onehot_scan_decoder_if #(
    parameter int SEL_W = 4,
    parameter int N     = 16
);
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] last;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] cur_sel;
    logic             wrap;
    logic             err;

    modport master (
        output en, mode, sel, last,
        input  out, cur_sel, wrap, err
    );

    modport slave (
        input  en, mode, sel, last,
        output out, cur_sel, wrap, err
    );
endinterface

// File: rtl/onehot_scan_decoder_dwell_counter.sv
// rtl/onehot_scan_decoder_dwell_counter.sv - modulo-DWELL counter with synchronous clear and terminal count
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] dwell_cnt;

    assign tc = (dwell_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (clr || tc) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered binary-to-one-hot decoder with auto-scan mode
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int N     = 16,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_scan_decoder_if.slave   dec
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

    state_t           state;
    logic [N-1:0]     out_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic             wrap_q;
    logic             err_q;

    logic             scan_run;
    logic             tc;
    logic             sel_oob;
    logic [SEL_W-1:0] eff_last;
    logic             at_last;
    logic [SEL_W-1:0] next_ch;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = N'(1) << idx;
    endfunction

    // Counter only runs while already scanning; any other cycle restarts the dwell.
    assign scan_run = dec.en && (dec.mode == MODE_SCAN) && (state == SCAN);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_run),
        .tc    (tc)
    );

    // Compares are widened by one bit so N == 2**SEL_W stays well-defined.
    assign sel_oob  = ({1'b0, dec.sel} >= (SEL_W + 1)'(N));
    assign eff_last = ({1'b0, dec.last} > {1'b0, LAST_CH}) ? LAST_CH : dec.last;
    assign at_last  = (cur_sel_q >= eff_last);
    assign next_ch  = at_last ? '0 : cur_sel_q + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_q     <= '0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (!dec.en) begin
            state  <= IDLE;
            out_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (dec.mode == MODE_DIRECT) begin
            state     <= DIRECT;
            cur_sel_q <= dec.sel;
            wrap_q    <= 1'b0;
            if (sel_oob) begin
                out_q <= '0;
                err_q <= 1'b1;
            end else begin
                out_q <= onehot(dec.sel);
                err_q <= 1'b0;
            end
        end else begin
            state <= SCAN;
            err_q <= 1'b0;
            if (state != SCAN) begin
                cur_sel_q <= '0;
                out_q     <= onehot('0);
                wrap_q    <= 1'b0;
            end else if (tc) begin
                cur_sel_q <= next_ch;
                out_q     <= onehot(next_ch);
                wrap_q    <= at_last;
            end else begin
                wrap_q <= 1'b0;
            end
        end
    end

    assign dec.out     = out_q;
    assign dec.cur_sel = cur_sel_q;
    assign dec.wrap    = wrap_q;
    assign dec.err     = err_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb/tb_onehot_scan_decoder.sv - directed self-checking bench for onehot_scan_decoder
module tb_onehot_scan_decoder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    onehot_scan_decoder_if #(.SEL_W(4), .N(16)) a_if ();
    onehot_scan_decoder_if #(.SEL_W(4), .N(10)) b_if ();

    onehot_scan_decoder #(.SEL_W(4), .N(16), .DWELL(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (a_if.slave)
    );

    onehot_scan_decoder #(.SEL_W(4), .N(10), .DWELL(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int ch, input logic wrap_exp);
        check({tag, "_out"}, 32'(a_if.out), 32'(1) << ch);
        check({tag, "_cur"}, 32'(a_if.cur_sel), 32'(ch));
        check({tag, "_wrap"}, 32'(a_if.wrap), 32'(wrap_exp));
        check({tag, "_onehot0"}, 32'($onehot0(a_if.out)), 32'd1);
    endtask

    task automatic check_b(input string tag, input int ch, input logic wrap_exp);
        check({tag, "_out"}, 32'(b_if.out), 32'(1) << ch);
        check({tag, "_cur"}, 32'(b_if.cur_sel), 32'(ch));
        check({tag, "_wrap"}, 32'(b_if.wrap), 32'(wrap_exp));
        check({tag, "_err"}, 32'(b_if.err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.en = 1'b0; a_if.mode = 1'b0; a_if.sel = '0; a_if.last = '0;
        b_if.en = 1'b0; b_if.mode = 1'b0; b_if.sel = '0; b_if.last = '0;
        repeat (2) tick();

        // reset state
        check("rst_a_out", 32'(a_if.out), 32'd0);
        check("rst_a_cur", 32'(a_if.cur_sel), 32'd0);
        check("rst_a_wrap", 32'(a_if.wrap), 32'd0);
        check("rst_a_err", 32'(a_if.err), 32'd0);
        check("rst_b_out", 32'(b_if.out), 32'd0);
        rst_n = 1'b1;

        // direct decode
        a_if.en = 1'b1; a_if.mode = 1'b0; a_if.sel = 4'd5;
        tick();
        check("dir5_out", 32'(a_if.out), 32'h0020);
        check("dir5_cur", 32'(a_if.cur_sel), 32'd5);
        check("dir5_err", 32'(a_if.err), 32'd0);
        check("dir5_wrap", 32'(a_if.wrap), 32'd0);
        for (int i = 0; i < 16; i++) begin
            a_if.sel = 4'(i);
            tick();
            check("sweep_out", 32'(a_if.out), 32'(1) << i);
            check("sweep_cur", 32'(a_if.cur_sel), 32'(i));
            check("sweep_err", 32'(a_if.err), 32'd0);
        end

        // out-of-range code on the N=10 instance
        b_if.en = 1'b1; b_if.mode = 1'b0; b_if.sel = 4'd12;
        tick();
        check("oob_out", 32'(b_if.out), 32'd0);
        check("oob_err", 32'(b_if.err), 32'd1);
        check("oob_cur", 32'(b_if.cur_sel), 32'd12);
        b_if.sel = 4'd3;
        tick();
        check("inr_out", 32'(b_if.out), 32'h008);
        check("inr_err", 32'(b_if.err), 32'd0);
        b_if.en = 1'b0;

        // scan 0..3, each channel held 4 cycles, wrap every 16
        a_if.mode = 1'b1; a_if.last = 4'd3;
        tick();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            check_a("scan", (k / 4) % 4, (k > 0) && (k % 16 == 0));
        end

        // enable drop: outputs off, cur_sel holds
        a_if.en = 1'b0;
        tick();
        check("en0_out", 32'(a_if.out), 32'd0);
        check("en0_cur", 32'(a_if.cur_sel), 32'd3);
        check("en0_wrap", 32'(a_if.wrap), 32'd0);
        check("en0_err", 32'(a_if.err), 32'd0);

        // restart with full dwell, then lower last while on channel 6
        a_if.en = 1'b1; a_if.last = 4'd7;
        tick();
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) tick();
            if (k < 28) check_a("lastchg", k / 4, 1'b0);
            else check_a("lastchg", ((k - 28) / 4) % 3, ((k - 28) % 12) == 0);
            if (k == 24) a_if.last = 4'd2;
        end

        // back to direct mode
        a_if.mode = 1'b0; a_if.sel = 4'd9;
        tick();
        check("dir9_out", 32'(a_if.out), 32'h0200);
        check("dir9_cur", 32'(a_if.cur_sel), 32'd9);
        check("dir9_wrap", 32'(a_if.wrap), 32'd0);

        // asynchronous reset between clock edges
        a_if.mode = 1'b1; a_if.last = 4'd3;
        tick();
        repeat (5) tick();
        check("pre_rst_cur", 32'(a_if.cur_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(a_if.out), 32'd0);
        check("arst_cur", 32'(a_if.cur_sel), 32'd0);
        check("arst_wrap", 32'(a_if.wrap), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check_a("post_rst", k / 4, 1'b0);
        end
        a_if.en = 1'b0;

        // DWELL=1: advance every cycle
        b_if.en = 1'b1; b_if.mode = 1'b1; b_if.last = 4'd3;
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            check_b("d1", k % 4, (k > 0) && (k % 4 == 0));
        end

        // last beyond N-1 clamps to 9
        b_if.en = 1'b0;
        tick();
        b_if.en = 1'b1; b_if.last = 4'd15;
        tick();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            check_b("clamp", k % 10, (k > 0) && (k % 10 == 0));
        end

        // last=0: channel 0 only, wrap every dwell
        b_if.en = 1'b0;
        tick();
        b_if.en = 1'b1; b_if.last = 4'd0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check_b("last0", 0, k > 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder with a selectable auto-scan mode.
- Direct mode: decodes an external select code into a one-hot output, one cycle of latency.
- Scan mode: cycles the active output through channels 0..last, holding each for a programmable dwell. Used to drive multiplexed 7-segment digit enables and LED rows.
- Sits between control logic and display/board enables; replaces the fixed 4-to-16 combinational decoder where timing or scanning is needed.

Parameters:
- SEL_W, 4, width of select codes.
- N, 16, number of one-hot outputs; 2 <= N <= 2**SEL_W.
- DWELL, 4, clock cycles each channel stays active in scan mode; >= 1.
- CNT_W, $clog2(DWELL+1), dwell counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; 0 forces all outputs inactive.
- mode  in  1  0 = direct decode, 1 = auto scan.
- sel  in  SEL_W  channel code in direct mode.
- last  in  SEL_W  highest channel visited in scan mode.
- out  out  N  registered one-hot (or all-zero) output.
- cur_sel  out  SEL_W  binary index of the active channel.
- wrap  out  1  one-cycle pulse when scan returns from last to 0.
- err  out  1  registered; high when direct-mode sel >= N.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, cur_sel=0, wrap=0, err=0, dwell_cnt=0, state=IDLE.
- All outputs are registered; nothing passes combinationally from input to output.

State machine, evaluated each rising edge:
- IDLE, entered when en=0:
  - out=0, wrap=0, err=0, dwell_cnt=0; cur_sel holds its value.
- DIRECT, entered when en=1 and mode=0:
  - out <= onehot(sel), cur_sel <= sel, latency 1 cycle.
  - If sel >= N: out <= 0, err <= 1, cur_sel <= sel.
  - wrap stays 0.
- SCAN, entered when en=1 and mode=1:
  - On entry from IDLE or DIRECT: cur_sel <= 0, out <= onehot(0), dwell_cnt <= 0, wrap <= 0.
  - While in SCAN, if dwell_cnt < DWELL-1: dwell_cnt increments; out and cur_sel hold.
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0 and the channel advances:
    - if cur_sel >= eff_last: cur_sel <= 0, wrap <= 1 for exactly that cycle;
    - otherwise cur_sel <= cur_sel+1.
  - out always equals onehot(cur_sel) in the same cycle.
  - eff_last = min(last, N-1), sampled every cycle.
  - err = 0 in SCAN.
- Transitions follow en/mode each cycle:
  - en has priority over mode.
  - A mode change takes effect on the next edge.
  - SCAN is re-entered from channel 0 after any exit.

Boundary conditions:
- DWELL=1: channel advances every cycle; wrap is high on the cycle cur_sel returns to 0.
- last=0 (or eff_last=0): out stays onehot(0); wrap pulses every DWELL cycles.
- last lowered mid-scan below cur_sel: the next advance wraps to 0 and pulses wrap. There is no immediate jump.
- last raised mid-scan: the new value applies at the next advance.
- rst_n asserted mid-scan: immediate reset values; after release, behaves as after power-up.
- en dropped and re-raised with mode=1: scan restarts at 0 with a full dwell.
- Invariant: out is one-hot or zero every cycle, never multi-hot.

Decomposition:
- Shared package decoder_pkg:
  - typedef enum for state {IDLE, DIRECT, SCAN};
  - localparam mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- One natural sub-module: dwell_counter, a parametrised modulo-DWELL counter with clear input and terminal-count output. Top level owns the FSM, channel register and one-hot encode.
- Expected size: about 150-220 lines total.

Test Plan:
- Reset then direct decode: rst_n low, then high; en=1, mode=0, sel=5. Cycle after: out=16'h0020, cur_sel=5, err=0. Sweep sel 0..15 → each single bit set with 1-cycle latency.
- Out-of-range code: N=10, sel=12 → out=0, err=1. Next sel=3 → out=10'h008, err=0.
- Scan wrap: mode=1, last=3, DWELL=4 → out cycles 0x1,0x2,0x4,0x8, each held 4 cycles. wrap is high for 1 cycle when out returns to 0x1, every 16 cycles.
- Last change mid-scan: scanning with last=7, while cur_sel=6 set last=2 → at the next dwell end cur_sel=0 and wrap=1. Subsequent cycle covers 0..2 only.
- Enable and mode interplay: en=0 during scan → next cycle out=0, cur_sel holds. en=1 → scan restarts with out=0x1 for the full DWELL. Switch to mode=0 with sel=9 → out=0x200 next cycle.
- Async reset mid-scan: pull rst_n low between clock edges → out=0, cur_sel=0, wrap=0 immediately without a clock. After release the scan restarts at channel 0; DWELL=1 variant advances every cycle.
